// File: rtl/pipe_stall_sequencer_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MUL     = 2'd1,
        MEMWAIT = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } stall_flush_t;

    localparam stall_flush_t SF_NONE = '0;

endpackage

// File: rtl/pipe_stall_sequencer_if.sv
// Hazard-side bundle: hazard requests in, per-stage stall/flush strobes out.
interface pipe_stall_sequencer_if #(
    parameter int PERF_W = 16
);
    logic              LDRstall;
    logic              BranchTakenE;
    logic              PCWrPendingF;
    logic              PCSrcW;
    logic              MulStartE;
    logic              MemReqM;
    logic              MemAckM;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic              FlushW;
    logic              MulBusy;
    logic [PERF_W-1:0] StallCount;

    modport master (
        output LDRstall, BranchTakenE, PCWrPendingF, PCSrcW, MulStartE, MemReqM, MemAckM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        input  MulBusy, StallCount
    );

    modport slave (
        input  LDRstall, BranchTakenE, PCWrPendingF, PCSrcW, MulStartE, MemReqM, MemAckM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
        output MulBusy, StallCount
    );
endinterface

// File: rtl/pipe_stall_sequencer_mul_timer.sv
// Down-counter tracking how many more cycles a multiply holds Execute.
module mul_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Load has priority over decrement; counter parks at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Central stall/flush sequencer for the F/D/E/M/W pipeline: merges control
// hazards, multi-cycle multiply occupancy and data-memory wait states.
module pipe_stall_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_stall_sequencer_if.slave bus
);

    // The start cycle is spent in RUN, so the counter covers the remaining MUL_CYCLES-1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

    if ((MUL_CYCLES < 2) || (MUL_CYCLES > (2 ** CNT_W))) begin : g_bad_mul_cycles
        $error("pipe_stall_sequencer: MUL_CYCLES=%0d outside 2..2**CNT_W", MUL_CYCLES);
    end

    pipe_state_t       state;
    pipe_state_t       state_nxt;
    stall_flush_t      sf;
    logic              mul_load;
    logic              mul_dec;
    logic              mul_zero;
    logic [CNT_W-1:0]  mul_cnt;
    logic              mem_wait;
    logic [PERF_W-1:0] stall_count;

    mul_timer #(.CNT_W(CNT_W)) u_mul_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (mul_load),
        .dec      (mul_dec),
        .load_val (MUL_LOAD),
        .cnt      (mul_cnt),
        .zero     (mul_zero)
    );

    // In MEMWAIT only the ack matters; the request is assumed held until acked.
    assign mem_wait = (state == MEMWAIT) ? !bus.MemAckM : (bus.MemReqM && !bus.MemAckM);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and same-cycle stall/flush decode; memory wait outranks multiply start,
    // which outranks control hazards.
    always_comb begin
        sf        = SF_NONE;
        state_nxt = state;
        mul_load  = 1'b0;
        mul_dec   = 1'b0;
        if (reset) begin
            sf.flush_d = 1'b1;
            sf.flush_e = 1'b1;
            sf.flush_m = 1'b1;
            sf.flush_w = 1'b1;
        end else begin
            case (state)
                MUL: begin
                    sf.stall_f = 1'b1;
                    sf.stall_d = 1'b1;
                    sf.stall_e = 1'b1;
                    sf.flush_m = 1'b1;
                    if (mul_zero) begin
                        state_nxt = RUN;
                    end else begin
                        mul_dec = 1'b1;
                    end
                end
                default: begin
                    if (mem_wait) begin
                        sf.stall_f = 1'b1;
                        sf.stall_d = 1'b1;
                        sf.stall_e = 1'b1;
                        sf.stall_m = 1'b1;
                        sf.flush_w = 1'b1;
                        state_nxt  = MEMWAIT;
                    end else if (bus.MulStartE) begin
                        sf.stall_f = 1'b1;
                        sf.stall_d = 1'b1;
                        sf.stall_e = 1'b1;
                        sf.flush_m = 1'b1;
                        mul_load   = 1'b1;
                        state_nxt  = MUL;
                    end else begin
                        sf.stall_f = bus.LDRstall | bus.PCWrPendingF;
                        sf.stall_d = bus.LDRstall;
                        sf.flush_d = bus.BranchTakenE | bus.PCWrPendingF | bus.PCSrcW;
                        sf.flush_e = bus.LDRstall | bus.BranchTakenE;
                        state_nxt  = RUN;
                    end
                end
            endcase
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (sf.stall_f && (stall_count != {PERF_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.StallF     = sf.stall_f;
    assign bus.StallD     = sf.stall_d;
    assign bus.StallE     = sf.stall_e;
    assign bus.StallM     = sf.stall_m;
    assign bus.FlushD     = sf.flush_d;
    assign bus.FlushE     = sf.flush_e;
    assign bus.FlushM     = sf.flush_m;
    assign bus.FlushW     = sf.flush_w;
    assign bus.MulBusy    = (state == MUL);
    assign bus.StallCount = stall_count;

endmodule
